// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch sequencer: FSM state encoding, opcode field
// position and parameter defaults.
package fetch_pkg;

  typedef enum logic [2:0] {
    S_RST   = 3'd0,
    S_REQ   = 3'd1,
    S_LOAD  = 3'd2,
    S_ISSUE = 3'd3,
    S_HALT  = 3'd4
  } fetch_state_t;

  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;

  localparam logic [15:0] DEF_RESET_VECTOR   = 16'h0000;
  localparam logic [15:0] DEF_PC_STEP        = 16'h0001;
  localparam logic [3:0]  DEF_HALT_OPCODE    = 4'hF;
  localparam int          DEF_TIMEOUT_CYCLES = 16;

  function automatic logic [3:0] opcode_of(input logic [15:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction bus between the fetch sequencer (master) and instruction memory
// (slave): single outstanding read with req/ack handshake.
interface fetch_ctrl_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ack
  );
endinterface

// File: rtl/fetch_timeout_cnt.sv
// Bus wait counter for the fetch sequencer; flags the cycle on which the
// TIMEOUT_CYCLES-th unacknowledged request cycle completes.
module fetch_timeout_cnt
  import fetch_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 16'd1;
    end
  end

  // Fires together with the final waiting cycle so the FSM leaves S_REQ on that edge.
  assign expired = inc & (cnt == LAST);

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer driving the IR/PC stage of the 16-bit RISC datapath.
// Optional bus timeout enabled by defining FETCH_TIMEOUT_EN.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_VECTOR   = DEF_RESET_VECTOR,
  parameter logic [15:0] PC_STEP        = DEF_PC_STEP,
  parameter logic [3:0]  HALT_OPCODE    = DEF_HALT_OPCODE,
  parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [15:0]   pc,
  fetch_ctrl_if.master  bus,
  output logic [15:0]   instr_in,
  output logic          instr_wr,
  output logic [15:0]   pc_in,
  output logic          pc_wr1,
  output logic          ir_valid,
  input  logic          ir_ready,
  input  logic          stall,
  input  logic          br_taken,
  input  logic [15:0]   br_target,
  output logic          halted,
  output logic          fetch_err
);

  fetch_state_t state;
  logic         accept;
  logic         is_halt;
  logic         timeout_hit;

  assign accept  = (state == S_ISSUE) & ir_ready & ~stall;
  assign is_halt = (opcode_of(instr_in) == HALT_OPCODE);

`ifdef FETCH_TIMEOUT_EN
  logic err_q;

  fetch_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state != S_REQ),
    .inc     ((state == S_REQ) & ~bus.imem_ack),
    .expired (timeout_hit)
  );

  assign fetch_err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign timeout_hit    = 1'b0;
  assign fetch_err      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_RST;
      instr_in <= '0;
      halted   <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      err_q    <= 1'b0;
`endif
    end else begin
      case (state)
        S_RST: state <= S_REQ;
        S_REQ: begin
          if (bus.imem_ack) begin
            instr_in <= bus.imem_rdata;
            state    <= S_LOAD;
          end else if (timeout_hit) begin
            state <= S_HALT;
`ifdef FETCH_TIMEOUT_EN
            err_q <= 1'b1;
`endif
          end
        end
        S_LOAD: state <= S_ISSUE;
        S_ISSUE: begin
          // HALT wins over a branch presented in the same accept cycle.
          if (accept) begin
            if (is_halt) begin
              state  <= S_HALT;
              halted <= 1'b1;
            end else begin
              state <= S_REQ;
            end
          end
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_RST;
      endcase
    end
  end

  // S_RST is also the state held during reset, so its PC strobe waits for release.
  always_comb begin
    pc_wr1 = 1'b0;
    pc_in  = '0;
    case (state)
      S_RST: begin
        pc_wr1 = rst_n;
        pc_in  = RESET_VECTOR;
      end
      S_LOAD: begin
        pc_wr1 = 1'b1;
        pc_in  = pc + PC_STEP;
      end
      S_ISSUE: begin
        if (accept & br_taken & ~is_halt) begin
          pc_wr1 = 1'b1;
          pc_in  = br_target;
        end
      end
      default: begin
        pc_wr1 = 1'b0;
        pc_in  = '0;
      end
    endcase
  end

  assign instr_wr      = (state == S_LOAD);
  assign ir_valid      = (state == S_ISSUE);
  assign bus.imem_req  = (state == S_REQ);
  assign bus.imem_addr = (state == S_REQ) ? pc : 16'h0000;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus randomized traffic, compared every
// cycle against a transaction-level model that also plays the IR/PC stage.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  localparam int TO_CYC = 16;
`ifdef FETCH_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pc = 16'h1234;
  logic        ir_ready = 1'b0, stall = 1'b0, br_taken = 1'b0;
  logic [15:0] br_target = 16'h0000;
  logic [15:0] instr_in, pc_in;
  logic        instr_wr, pc_wr1, ir_valid, halted, fetch_err;

  fetch_ctrl_if bus();

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pc        (pc),
    .bus       (bus),
    .instr_in  (instr_in),
    .instr_wr  (instr_wr),
    .pc_in     (pc_in),
    .pc_wr1    (pc_wr1),
    .ir_valid  (ir_valid),
    .ir_ready  (ir_ready),
    .stall     (stall),
    .br_taken  (br_taken),
    .br_target (br_target),
    .halted    (halted),
    .fetch_err (fetch_err)
  );

  int total = 0;
  int bad   = 0;

  // Model: phase 0 reset-vector write, 1 waiting on bus, 2 IR/PC load, 3 presenting, 4 stopped
  int          m_ph = 0;
  int          m_wait = 0;
  logic [15:0] m_instr = 16'h0000;
  bit          m_halted = 1'b0, m_err = 1'b0;
  logic [15:0] m_pc_nxt = 16'h1234;

  logic        e_req, e_iwr, e_pwr, e_valid;
  logic [15:0] e_addr, e_pin;
  logic        s_req, s_iwr, s_pwr, s_valid, s_halted, s_err;
  logic [15:0] s_addr, s_pin, s_instr;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic bit accepted();
    return ir_ready && !stall;
  endfunction

  task automatic check_all();
    e_req   = (m_ph == 1);
    e_addr  = e_req ? pc : 16'h0000;
    e_iwr   = (m_ph == 2);
    e_valid = (m_ph == 3);
    e_pwr   = 1'b0;
    e_pin   = 16'h0000;
    if (m_ph == 0) begin e_pwr = 1'b1; e_pin = 16'h0000; end
    if (m_ph == 2) begin e_pwr = 1'b1; e_pin = pc + 16'd1; end
    if (m_ph == 3 && accepted() && br_taken && m_instr[15:12] != 4'hF) begin
      e_pwr = 1'b1; e_pin = br_target;
    end
    s_req = bus.imem_req; s_addr = bus.imem_addr; s_iwr = instr_wr; s_pwr = pc_wr1;
    s_pin = pc_in; s_valid = ir_valid; s_instr = instr_in; s_halted = halted; s_err = fetch_err;
    chk("imem_req", s_req, e_req);
    chk("imem_addr", s_addr, e_addr);
    chk("instr_wr", s_iwr, e_iwr);
    chk("pc_wr1", s_pwr, e_pwr);
    if (e_pwr) chk("pc_in", s_pin, e_pin);
    chk("ir_valid", s_valid, e_valid);
    chk("instr_in", s_instr, m_instr);
    chk("halted", s_halted, m_halted);
    chk("fetch_err", s_err, m_err);
  endtask

  task automatic model_step();
    m_pc_nxt = e_pwr ? e_pin : pc;
    case (m_ph)
      0: begin m_ph = 1; m_wait = 0; end
      1: begin
        if (bus.imem_ack) begin
          m_instr = bus.imem_rdata; m_ph = 2;
        end else begin
          m_wait++;
          if (TO_EN && m_wait == TO_CYC) begin m_err = 1'b1; m_ph = 4; end
        end
      end
      2: m_ph = 3;
      3: if (accepted()) begin
        if (m_instr[15:12] == 4'hF) begin m_halted = 1'b1; m_ph = 4; end
        else begin m_ph = 1; m_wait = 0; end
      end
      default: ;
    endcase
  endtask

  // Entered just after a rising edge with inputs already set; returns just after the next one.
  task automatic cyc();
    @(negedge clk);
    check_all();
    model_step();
    @(posedge clk);
    #1;
    pc = m_pc_nxt;
  endtask

  task automatic do_reset();
    #3;
    rst_n = 1'b0;
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 16'h5A5A;
    #1;
    chk("rst_req", bus.imem_req, 16'h0);
    chk("rst_addr", bus.imem_addr, 16'h0);
    chk("rst_iwr", instr_wr, 16'h0);
    chk("rst_pwr", pc_wr1, 16'h0);
    chk("rst_valid", ir_valid, 16'h0);
    chk("rst_halted", halted, 16'h0);
    chk("rst_err", fetch_err, 16'h0);
    chk("rst_instr", instr_in, 16'h0);
    m_ph = 0; m_wait = 0; m_instr = 16'h0000; m_halted = 1'b0; m_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack_dropped", instr_in, 16'h0);
    rst_n = 1'b1;
  endtask

  task automatic set_in(input logic ack, input logic [15:0] rd, input logic rdy,
                        input logic stl, input logic br, input logic [15:0] tgt);
    bus.imem_ack = ack; bus.imem_rdata = rd; ir_ready = rdy;
    stall = stl; br_taken = br; br_target = tgt;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    int stop_cnt;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = 16'h0000;
    @(posedge clk); #1;
    do_reset();

    // Boot sequence with immediate ack/accept
    set_in(1'b1, 16'hA8B7, 1'b1, 1'b0, 1'b0, 16'h0000);
    cyc(); chk("c1_pwr", s_pwr, 16'h1); chk("c1_pin", s_pin, 16'h0000);
    cyc(); chk("c2_req", s_req, 16'h1); chk("c2_addr", s_addr, 16'h0000);
    cyc(); chk("c3_iwr", s_iwr, 16'h1); chk("c3_instr", s_instr, 16'hA8B7); chk("c3_pin", s_pin, 16'h0001);
    cyc(); chk("c4_valid", s_valid, 16'h1); chk("c4_pwr", s_pwr, 16'h0);

    // Hold: not ready, then stalled; ack and branch noise must be ignored
    set_in(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h0000);
    cyc(); chk("h_addr", s_addr, 16'h0001);
    cyc();
    set_in(1'b1, 16'h4444, 1'b0, 1'b0, 1'b1, 16'hDEAD);
    for (int i = 0; i < 7; i++) begin
      if (i == 5) begin ir_ready = 1'b1; stall = 1'b1; end
      cyc();
      chk("h_valid", s_valid, 16'h1); chk("h_instr", s_instr, 16'h1234);
      chk("h_pwr", s_pwr, 16'h0); chk("h_req", s_req, 16'h0);
    end
    set_in(1'b1, 16'h0777, 1'b1, 1'b0, 1'b0, 16'h0000);
    cyc(); chk("h_rel_pwr", s_pwr, 16'h0);
    cyc(); chk("h_next_req", s_req, 16'h1); chk("h_next_addr", s_addr, 16'h0002);

    // Branch, then branch to FFFF to exercise PC wrap
    cyc();
    set_in(1'b1, 16'h0888, 1'b1, 1'b0, 1'b1, 16'hB7A8);
    cyc(); chk("br_pwr", s_pwr, 16'h1); chk("br_pin", s_pin, 16'hB7A8);
    br_taken = 1'b0;
    cyc(); chk("br_addr", s_addr, 16'hB7A8);
    cyc(); chk("br_load_pin", s_pin, 16'hB7A9);
    br_taken = 1'b1; br_target = 16'hFFFF;
    cyc(); chk("wr_pin", s_pin, 16'hFFFF);
    br_taken = 1'b0;
    cyc(); chk("wr_addr", s_addr, 16'hFFFF);
    cyc(); chk("wr_load_pin", s_pin, 16'h0000);
    cyc();
    cyc(); chk("wr_next_addr", s_addr, 16'h0000);

    // HALT accepted together with a branch
    do_reset();
    set_in(1'b1, 16'hF123, 1'b1, 1'b0, 1'b1, 16'h1111);
    repeat (3) cyc();
    cyc(); chk("halt_valid", s_valid, 16'h1); chk("halt_pwr", s_pwr, 16'h0);
    for (int i = 0; i < 6; i++) begin
      cyc(); chk("halt_flag", s_halted, 16'h1); chk("halt_req", s_req, 16'h0);
    end

    // Reset asserted in the middle of a bus wait
    do_reset();
    set_in(1'b0, 16'h2222, 1'b1, 1'b0, 1'b0, 16'h0000);
    repeat (3) cyc();
    chk("mid_req_before", s_req, 16'h1);
    do_reset();

    // Bus never acknowledges
    set_in(1'b0, 16'h3333, 1'b1, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (i == 17) begin
        chk("to_err", s_err, TO_EN ? 16'h1 : 16'h0);
        chk("to_req", s_req, TO_EN ? 16'h0 : 16'h1);
        chk("to_halted", s_halted, 16'h0);
      end
    end
    chk("to_end_req", s_req, TO_EN ? 16'h0 : 16'h1);

    // Randomized traffic
    do_reset();
    stop_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      rd = 16'($urandom);
      if (rd[15:12] == 4'hF && $urandom_range(0, 7) != 0) rd[15:12] = 4'h3;
      set_in(($urandom_range(0, 3) != 0), rd, ($urandom_range(0, 9) < 7),
             ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) < 3),
             ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom));
      cyc();
      stop_cnt = (m_ph == 4) ? stop_cnt + 1 : 0;
      if (stop_cnt > 3 || $urandom_range(0, 299) == 0) begin
        do_reset();
        stop_cnt = 0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
